ac_rle_encoder: RTL



---
 rtl/jpeg_pkg.sv | 29 ++
 rtl/ac_size_calc.sv | 71 +++++++
 rtl/ac_rle_encoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jpeg_pkg
// Description : Shared constants and types for the JPEG AC entropy path.
//               Holds the coefficient/amplitude widths, the maximum AC
//               magnitude category, the ZRL/EOB symbol encodings and the
//               run-length encoder state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package jpeg_pkg;

    localparam int COEF_W      = 12;                 // signed quantized AC coefficient
    localparam int AMP_W       = 10;                 // amplitude (extra bits) field
    localparam int AC_MAX_SIZE = 10;                 // largest AC magnitude category
    localparam int AMP_MAX     = (1 << AMP_W) - 1;   // largest representable |coef|
    localparam int ZRL_LEN     = 16;                 // zeros covered by one ZRL symbol

    localparam logic [3:0] ZRL_RUN  = 4'hF;
    localparam logic [3:0] ZRL_SIZE = 4'h0;
    localparam logic [3:0] EOB_RUN  = 4'h0;
    localparam logic [3:0] EOB_SIZE = 4'h0;

    typedef enum logic [0:0] {
        RUN = 1'b0,   // accepting coefficients
        ZRL = 1'b1    // flushing ZRLs ahead of a held nonzero coefficient
    } ac_state_e;

endpackage
`default_nettype wire

// File: rtl/ac_size_calc.sv
`default_nettype none
// ============================================================================
// Module      : ac_size_calc
// Description : Combinational magnitude-category / amplitude calculator for
//               one signed AC coefficient.
//                 coef : signed quantized coefficient (COEF_W)
//                 size : number of significant bits of |coef|, 0..10
//                 amp  : extra bits, LSB-aligned, upper bits zero (AMP_W)
//                 ovf  : |coef| exceeds the 10-bit AC range
//               Build option JPEG_AC_CLIP_EN: saturate |coef| to 1023 before
//               encoding and never flag ovf. Without it, size is clamped to
//               10, amp keeps the low 10 bits and ovf reports the overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_size_calc
    import jpeg_pkg::*;
(
    input  logic [COEF_W-1:0] coef,
    output logic [3:0]        size,
    output logic [AMP_W-1:0]  amp,
    output logic              ovf
);

    logic [COEF_W-1:0] w_val;     // coefficient after optional saturation
    logic [COEF_W:0]   w_ext;     // sign-extended by one bit so -2^(COEF_W-1) has a magnitude
    logic [COEF_W:0]   w_mag;
    logic [4:0]        w_bits;
    logic [AMP_W-1:0]  w_adj;
    logic [AMP_W-1:0]  w_mask;

`ifdef JPEG_AC_CLIP_EN
    always_comb begin
        if ($signed(coef) > $signed(COEF_W'(AMP_MAX))) begin
            w_val = COEF_W'(AMP_MAX);
        end else if ($signed(coef) < -$signed(COEF_W'(AMP_MAX))) begin
            w_val = -COEF_W'(AMP_MAX);
        end else begin
            w_val = coef;
        end
    end
    assign ovf = 1'b0;
`else
    assign w_val = coef;
    assign ovf   = (w_mag > (COEF_W + 1)'(AMP_MAX));
`endif

    assign w_ext = {w_val[COEF_W-1], w_val};
    assign w_mag = w_ext[COEF_W] ? (~w_ext + 1'b1) : w_ext;

    // Position of the highest set bit of the magnitude, 1-based.
    always_comb begin
        w_bits = 5'd0;
        for (int i = 0; i <= COEF_W; i++) begin
            if (w_mag[i]) begin
                w_bits = 5'(i + 1);
            end
        end
    end

    assign size = (w_bits > 5'(AC_MAX_SIZE)) ? 4'(AC_MAX_SIZE) : w_bits[3:0];

    // Negative values send the one's complement, i.e. (coef - 1).
    assign w_adj = w_ext[COEF_W] ? (w_val[AMP_W-1:0] - AMP_W'(1)) : w_val[AMP_W-1:0];

    // For size == AMP_W the shift wraps to zero and the subtract yields
    // all ones, which is exactly the full-width mask wanted.
    assign w_mask = (AMP_W'(1) << size) - AMP_W'(1);
    assign amp    = w_adj & w_mask;

endmodule
`default_nettype wire

// File: rtl/ac_rle_encoder.sv
`default_nettype none
// ============================================================================
// Module      : ac_rle_encoder
// Description : Run-length / size encoder for the 63 AC coefficients of an
//               8x8 block in zigzag order. Emits (run, size, amp) symbols,
//               ZRL (F/0) for every 16 zeros ahead of a later nonzero, and
//               EOB (0/0) when the block ends in zeros.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     coef_vld/coef_rdy          coefficient handshake
//     coef, coef_last            signed coefficient, last-of-block marker
//     sym_vld/sym_rdy            symbol handshake
//     sym_run, sym_size, sym_amp symbol fields
//     sym_eob                    symbol is EOB (end of block)
//     err_ovf                    sticky out-of-range coefficient flag
//   Build option JPEG_AC_CLIP_EN selects saturating coefficients (err_ovf
//   then stays 0); see ac_size_calc.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_rle_encoder
    import jpeg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_vld,
    output logic              coef_rdy,
    input  logic [COEF_W-1:0] coef,
    input  logic              coef_last,
    output logic              sym_vld,
    input  logic              sym_rdy,
    output logic [3:0]        sym_run,
    output logic [3:0]        sym_size,
    output logic [AMP_W-1:0]  sym_amp,
    output logic              sym_eob,
    output logic              err_ovf
);

    ac_state_e         r_state;
    ac_state_e         w_state_nxt;
    logic [5:0]        r_zero_cnt;
    logic [5:0]        w_zero_cnt_nxt;
    logic [COEF_W-1:0] r_hold_coef;
    logic [COEF_W-1:0] w_hold_coef_nxt;
    logic              r_err_ovf;

    logic              r_sym_vld;
    logic [3:0]        r_sym_run;
    logic [3:0]        r_sym_size;
    logic [AMP_W-1:0]  r_sym_amp;
    logic              r_sym_eob;

    logic              w_sym_load;
    logic [3:0]        w_sym_run;
    logic [3:0]        w_sym_size;
    logic [AMP_W-1:0]  w_sym_amp;
    logic              w_sym_eob;

    logic              w_slot_free;
    logic              w_coef_rdy;
    logic              w_accept;
    logic              w_coef_zero;
    logic              w_run_ge16;
    logic [COEF_W-1:0] w_calc_coef;
    logic [3:0]        w_size;
    logic [AMP_W-1:0]  w_amp;
    logic              w_ovf;

    // The size calculator sees the live input in RUN and the held
    // coefficient while ZRLs are being flushed ahead of it.
    assign w_calc_coef = (r_state == ZRL) ? r_hold_coef : coef;

    ac_size_calc u_size_calc (
        .coef (w_calc_coef),
        .size (w_size),
        .amp  (w_amp),
        .ovf  (w_ovf)
    );

    assign w_slot_free = !r_sym_vld || sym_rdy;
    assign w_coef_rdy  = !rst && (r_state == RUN) && w_slot_free;
    assign w_accept    = coef_vld && w_coef_rdy;
    assign w_coef_zero = (coef == '0);
    assign w_run_ge16  = (r_zero_cnt >= 6'(ZRL_LEN));

    // The held coefficient's last flag is not kept: emitting it always
    // clears zero_cnt and returns to RUN, which already ends the block.
    always_comb begin
        w_state_nxt     = r_state;
        w_zero_cnt_nxt  = r_zero_cnt;
        w_hold_coef_nxt = r_hold_coef;
        w_sym_load      = 1'b0;
        w_sym_run       = 4'd0;
        w_sym_size      = 4'd0;
        w_sym_amp       = '0;
        w_sym_eob       = 1'b0;

        case (r_state)
            RUN: begin
                if (w_accept) begin
                    if (w_coef_zero) begin
                        if (coef_last) begin
                            // Trailing zeros of any length collapse into EOB.
                            w_sym_load     = 1'b1;
                            w_sym_run      = EOB_RUN;
                            w_sym_size     = EOB_SIZE;
                            w_sym_eob      = 1'b1;
                            w_zero_cnt_nxt = 6'd0;
                        end else begin
                            w_zero_cnt_nxt = r_zero_cnt + 6'd1;
                        end
                    end else if (!w_run_ge16) begin
                        w_sym_load     = 1'b1;
                        w_sym_run      = r_zero_cnt[3:0];
                        w_sym_size     = w_size;
                        w_sym_amp      = w_amp;
                        w_zero_cnt_nxt = 6'd0;
                    end else begin
                        w_hold_coef_nxt = coef;
                        w_sym_load      = 1'b1;
                        w_sym_run       = ZRL_RUN;
                        w_sym_size      = ZRL_SIZE;
                        w_zero_cnt_nxt  = r_zero_cnt - 6'(ZRL_LEN);
                        w_state_nxt     = ZRL;
                    end
                end
            end
            ZRL: begin
                if (w_slot_free && !rst) begin
                    w_sym_load = 1'b1;
                    if (w_run_ge16) begin
                        w_sym_run      = ZRL_RUN;
                        w_sym_size     = ZRL_SIZE;
                        w_zero_cnt_nxt = r_zero_cnt - 6'(ZRL_LEN);
                    end else begin
                        w_sym_run      = r_zero_cnt[3:0];
                        w_sym_size     = w_size;
                        w_sym_amp      = w_amp;
                        w_zero_cnt_nxt = 6'd0;
                        w_state_nxt    = RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_zero_cnt  <= 6'd0;
            r_hold_coef <= '0;
            r_err_ovf   <= 1'b0;
            r_sym_vld   <= 1'b0;
            r_sym_run   <= 4'd0;
            r_sym_size  <= 4'd0;
            r_sym_amp   <= '0;
            r_sym_eob   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_cnt  <= w_zero_cnt_nxt;
            r_hold_coef <= w_hold_coef_nxt;
            if (w_accept && w_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_sym_load) begin
                r_sym_vld  <= 1'b1;
                r_sym_run  <= w_sym_run;
                r_sym_size <= w_sym_size;
                r_sym_amp  <= w_sym_amp;
                r_sym_eob  <= w_sym_eob;
            end else if (sym_rdy) begin
                r_sym_vld  <= 1'b0;
            end
        end
    end

    assign coef_rdy = w_coef_rdy;
    assign sym_vld  = r_sym_vld;
    assign sym_run  = r_sym_run;
    assign sym_size = r_sym_size;
    assign sym_amp  = r_sym_amp;
    assign sym_eob  = r_sym_eob;
    assign err_ovf  = r_err_ovf;

endmodule
`default_nettype wire
